// File: rtl/entity_slot_scheduler_if.sv
// Requester-side bundle for the entity slot scheduler: two write ports,
// each a valid/ready handshake carrying a slot index and an entity word.
interface entity_slot_scheduler_if;
   logic        req0_valid;
   logic [3:0]  req0_slot;
   logic [13:0] req0_data;
   logic        req0_ready;
   logic        req1_valid;
   logic [3:0]  req1_slot;
   logic [13:0] req1_data;
   logic        req1_ready;

   // Game-logic side: drives requests, observes acceptance.
   modport master (
      output req0_valid, req0_slot, req0_data,
      output req1_valid, req1_slot, req1_data,
      input  req0_ready, req1_ready
   );

   // Scheduler side.
   modport slave (
      input  req0_valid, req0_slot, req0_data,
      input  req1_valid, req1_slot, req1_data,
      output req0_ready, req1_ready
   );
endinterface

// File: rtl/entity_slot_scheduler.sv
// Entity slot scheduler: two round-robin requesters write a 9-entry shadow
// table; at the start of vertical blanking (or on force_commit) the shadow
// table is copied one slot per cycle into the active table that feeds the
// frame buffer, so entity_1..entity_9 never change during active video.
module entity_slot_scheduler #(
   parameter logic [9:0]  V_TRIGGER   = 10'd480,
   parameter logic [9:0]  H_TRIGGER   = 10'd0,
   parameter logic [13:0] IDLE_ENTITY = 14'h3C00
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [9:0]                    counter_V,
   input  logic [9:0]                    counter_H,
   input  logic                          force_commit,
   entity_slot_scheduler_if.slave        req,
   output logic [13:0]                   entity_1,
   output logic [13:0]                   entity_2,
   output logic [13:0]                   entity_3,
   output logic [13:0]                   entity_4,
   output logic [13:0]                   entity_5,
   output logic [13:0]                   entity_6,
   output logic [13:0]                   entity_7,
   output logic [13:0]                   entity_8,
   output logic [13:0]                   entity_9,
   output logic                          commit_busy,
   output logic                          commit_done,
   output logic                          slot_err
);

   typedef enum logic {S_IDLE, S_COMMIT} state_t;

   state_t            state_q, state_d;
   logic [3:0]        idx_q, idx_d;
   logic [8:0][13:0]  shadow_q;
   logic [8:0][13:0]  active_q;
   logic              last_grant_q;   // 1 = requester 1 was granted most recently
   logic              done_q, done_d;
   logic              slot_err_q;

   logic              trigger;
   logic              gnt0, gnt1;
   logic              wr_en;
   logic [3:0]        wr_slot;
   logic [13:0]       wr_data;

   assign trigger = ((counter_V == V_TRIGGER) && (counter_H == H_TRIGGER)) || force_commit;

   // Next state, commit index and round-robin grant; writes only in IDLE off the trigger cycle.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      done_d  = 1'b0;
      gnt0    = 1'b0;
      gnt1    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (trigger) begin
               state_d = S_COMMIT;
               idx_d   = 4'd0;
            end else begin
               if (req.req0_valid && (!req.req1_valid || last_grant_q)) gnt0 = 1'b1;
               else if (req.req1_valid)                                gnt1 = 1'b1;
            end
         end
         S_COMMIT: begin
            // Triggers seen here are dropped; the sequence is a fixed 9 copies.
            if (idx_q == 4'd8) begin
               state_d = S_IDLE;
               idx_d   = 4'd0;
               done_d  = 1'b1;
            end else begin
               idx_d = idx_q + 4'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (reset) begin
         gnt0 = 1'b0;
         gnt1 = 1'b0;
      end
   end

   assign req.req0_ready = gnt0;
   assign req.req1_ready = gnt1;

   assign wr_en   = gnt0 | gnt1;
   assign wr_slot = gnt0 ? req.req0_slot : req.req1_slot;
   assign wr_data = gnt0 ? req.req0_data : req.req1_data;

   // FSM state, commit index, and status pulses.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         idx_q        <= 4'd0;
         done_q       <= 1'b0;
         slot_err_q   <= 1'b0;
         last_grant_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         done_q     <= done_d;
         // Out-of-range slots are consumed but flagged one cycle later.
         slot_err_q <= wr_en && (wr_slot > 4'd8);
         if (wr_en) last_grant_q <= gnt1;
      end
   end

   // Shadow table: the last accepted write to a slot before a commit wins.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < 9; k++) shadow_q[k] <= IDLE_ENTITY;
      end else if (wr_en && (wr_slot <= 4'd8)) begin
         shadow_q[wr_slot] <= wr_data;
      end
   end

   // Active table: one slot copied per COMMIT cycle, slot 0 first.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < 9; k++) active_q[k] <= IDLE_ENTITY;
      end else if (state_q == S_COMMIT) begin
         active_q[idx_q] <= shadow_q[idx_q];
      end
   end

   assign entity_1    = active_q[0];
   assign entity_2    = active_q[1];
   assign entity_3    = active_q[2];
   assign entity_4    = active_q[3];
   assign entity_5    = active_q[4];
   assign entity_6    = active_q[5];
   assign entity_7    = active_q[6];
   assign entity_8    = active_q[7];
   assign entity_9    = active_q[8];
   assign commit_busy = (state_q == S_COMMIT);
   assign commit_done = done_q;
   assign slot_err    = slot_err_q;

endmodule
